// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and region decode helpers for the VGA timing generator.
// All constants are 10-bit so counter comparisons stay width-matched.
package vga_timing_pkg;

    localparam logic [9:0] H_VISIBLE       = 10'd640;
    localparam logic [9:0] H_FP            = 10'd16;
    localparam logic [9:0] H_SYNC          = 10'd96;
    localparam logic [9:0] H_BP            = 10'd48;
    localparam logic [9:0] H_TOTAL         = 10'd800;

    localparam logic [9:0] V_VISIBLE       = 10'd480;
    localparam logic [9:0] V_FP            = 10'd10;
    localparam logic [9:0] V_SYNC          = 10'd2;
    localparam logic [9:0] V_BP            = 10'd33;
    localparam logic [9:0] V_TOTAL         = 10'd525;

    localparam logic [9:0] FRAME_TICK_LINE = 10'd481;

    localparam logic [9:0] H_SYNC_START    = H_VISIBLE + H_FP;
    localparam logic [9:0] H_BP_START      = H_SYNC_START + H_SYNC;
    localparam logic [9:0] H_LAST          = H_TOTAL - 10'd1;

    localparam logic [9:0] V_SYNC_START    = V_VISIBLE + V_FP;
    localparam logic [9:0] V_BP_START      = V_SYNC_START + V_SYNC;
    localparam logic [9:0] V_LAST          = V_TOTAL - 10'd1;

    typedef enum logic [1:0] {
        REGION_VISIBLE,
        REGION_FRONT_PORCH,
        REGION_SYNC,
        REGION_BACK_PORCH
    } region_t;

    function automatic region_t h_region(input logic [9:0] hx);
        region_t r;
        if (hx < H_VISIBLE)         r = REGION_VISIBLE;
        else if (hx < H_SYNC_START) r = REGION_FRONT_PORCH;
        else if (hx < H_BP_START)   r = REGION_SYNC;
        else                        r = REGION_BACK_PORCH;
        return r;
    endfunction

    function automatic region_t v_region(input logic [9:0] vy);
        region_t r;
        if (vy < V_VISIBLE)         r = REGION_VISIBLE;
        else if (vy < V_SYNC_START) r = REGION_FRONT_PORCH;
        else if (vy < V_BP_START)   r = REGION_SYNC;
        else                        r = REGION_BACK_PORCH;
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_div.sv
// pixel_tick_div: divides the system clock down to a one-clk-in-CLK_DIV pixel enable strobe.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Gating with reset keeps the strobe low during reset even when CLK_DIV is 1.
    assign p_tick = (div_cnt == DIV_LAST) && !reset;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator: pixel divider, x/y raster counters, sync and frame strobes.
// Define VGA_TIMING_FRAMECNT_EN to build the 16-bit frame counter; otherwise frame_count is 0.
module vga_timing_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    import vga_timing_pkg::*;

    logic [9:0] x_next;
    logic [9:0] y_next;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == H_LAST) begin
                x_next = '0;
                y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Syncs and frame_tick decode the next-state counters so they switch on the same edge as x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_next;
            y          <= y_next;
            hsync      <= (h_region(x_next) != REGION_SYNC);
            vsync      <= (v_region(y_next) != REGION_SYNC);
            frame_tick <= p_tick && (x_next == 10'd0) && (y_next == FRAME_TICK_LINE);
        end
    end

    assign video_on = (h_region(x) == REGION_VISIBLE) && (v_region(y) == REGION_VISIBLE);

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_cnt_q <= '0;
        else if (frame_tick)
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a closed-form raster model feeds a per-clk scoreboard queue,
// and scenario tasks check reset, line/frame wrap, sync widths, frame ticks and mid-frame reset.
module tb_vga_timing_gen;

    localparam int     CLK_DIV       = 4;
    localparam longint PIX_PER_FRAME = 420000;
    localparam longint TICK_PIX      = 481 * 800;
    localparam longint FRAME_CLKS    = PIX_PER_FRAME * CLK_DIV;
`ifdef VGA_TIMING_FRAMECNT_EN
    localparam logic [15:0] EXP_FC_AFTER_3 = 16'd3;
`else
    localparam logic [15:0] EXP_FC_AFTER_3 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_tick;
    logic [15:0] frame_count;

    int          checks = 0;
    int          failures = 0;
    bit          abort = 1'b0;
    bit          sb_on = 1'b0;
    longint      n = 0;
    logic [40:0] exp_q[$];
    logic [40:0] sb_exp;
    logic [40:0] sb_obs;
    longint      tick_n[$];
    logic [19:0] tick_xy[$];
    int          wide_ticks = 0;
    logic        prev_ft = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (p_tick),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    // Expected outputs after k clock edges since reset release, derived from raster arithmetic.
    function automatic logic [40:0] model(input longint k);
        longint p;
        int ix, iy;
        logic ept, evid, ehs, evs, eft;
        logic [15:0] efc;
        p    = k / CLK_DIV;
        ix   = int'(p % 800);
        iy   = int'((p / 800) % 525);
        ept  = ((k % CLK_DIV) == longint'(CLK_DIV - 1));
        evid = (ix < 640) && (iy < 480);
        ehs  = !((ix >= 656) && (ix <= 751));
        evs  = !((iy >= 490) && (iy <= 491));
        eft  = ((k % CLK_DIV) == 0) && ((p % PIX_PER_FRAME) == TICK_PIX);
        efc  = 16'd0;
`ifdef VGA_TIMING_FRAMECNT_EN
        if (k > TICK_PIX * CLK_DIV)
            efc = 16'((k - 1 - TICK_PIX * CLK_DIV) / FRAME_CLKS + 1);
`endif
        return {ept, 10'(ix), 10'(iy), evid, ehs, evs, eft, efc};
    endfunction

    always @(posedge clk) begin
        if (reset)
            n <= 0;
        else if (sb_on) begin
            n <= n + 1;
            exp_q.push_back(model(n + 1));
        end
    end

    task automatic step();
        @(negedge clk);
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_obs = {p_tick, x, y, video_on, hsync, vsync, frame_tick, frame_count};
            checks++;
            if (sb_obs !== sb_exp) begin
                failures++;
                $display("[TB] FAIL stream edge=%0d observed=%h expected=%h", n, sb_obs, sb_exp);
                if (failures > 20) abort = 1'b1;
            end
        end
        if (sb_on && frame_tick === 1'b1) begin
            tick_n.push_back(n);
            tick_xy.push_back({x, y});
            if (prev_ft === 1'b1) wide_ticks++;
        end
        prev_ft = frame_tick;
    endtask

    task automatic release_reset();
        @(negedge clk);
        exp_q.delete();
        tick_n.delete();
        tick_xy.delete();
        wide_ticks = 0;
        prev_ft = 1'b0;
        sb_on = 1'b1;
        reset = 1'b0;
    endtask

    task automatic test_first_tick(input string tag);
        int first = 0;
        for (int c = 1; c <= 4 * CLK_DIV && first == 0; c++) begin
            step();
            if (p_tick === 1'b1) first = c + 1;
        end
        checks++;
        if (first != CLK_DIV) begin
            failures++;
            $display("[TB] FAIL %s_first_p_tick clk=%0d required=%0d", tag, first, CLK_DIV);
        end
        step();
        checks++;
        if (x !== 10'd1 || y !== 10'd0) begin
            failures++;
            $display("[TB] FAIL %s_after_first_tick x=%0d y=%0d required x=1 y=0", tag, x, y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sb_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (x !== 10'd0 || y !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_xy x=%0d y=%0d required 0,0", x, y);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_sync hsync=%b vsync=%b required 1,1", hsync, vsync);
        end
        checks++;
        if (p_tick !== 1'b0 || frame_tick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ticks p_tick=%b frame_tick=%b required 0,0", p_tick, frame_tick);
        end
        checks++;
        if (video_on !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_video_on got=%b required=1", video_on);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_frame_count got=%0d required=0", frame_count);
        end
        release_reset();
        test_first_tick("reset");
    endtask

    task automatic test_line();
        int hs_clks = 0;
        int hs_pix = 0;
        int min_x = 1023;
        int max_x = -1;
        int budget = 0;
        bit wrapped = 1'b0;
        logic [9:0] px, py;
        px = x;
        py = y;
        while (!wrapped && budget < 900 * CLK_DIV && !abort) begin
            step();
            budget++;
            if (hsync === 1'b0) begin
                hs_clks++;
                if (p_tick === 1'b1) hs_pix++;
                if (int'(x) < min_x) min_x = int'(x);
                if (int'(x) > max_x) max_x = int'(x);
            end
            if (px == 10'd799 && x != 10'd799) begin
                wrapped = 1'b1;
                checks++;
                if (x !== 10'd0 || y !== py + 10'd1) begin
                    failures++;
                    $display("[TB] FAIL line_wrap x=%0d y=%0d required x=0 y=%0d", x, y, py + 10'd1);
                end
            end
            px = x;
            py = y;
        end
        checks++;
        if (!wrapped) begin
            failures++;
            $display("[TB] FAIL line_wrap_timeout clks=%0d required wrap within %0d", budget, 900 * CLK_DIV);
        end
        checks++;
        if (hs_clks != 96 * CLK_DIV) begin
            failures++;
            $display("[TB] FAIL hsync_low_clks got=%0d required=%0d", hs_clks, 96 * CLK_DIV);
        end
        checks++;
        if (hs_pix != 96) begin
            failures++;
            $display("[TB] FAIL hsync_low_pixels got=%0d required=96", hs_pix);
        end
        checks++;
        if (min_x != 656 || max_x != 751) begin
            failures++;
            $display("[TB] FAIL hsync_window x=%0d..%0d required 656..751", min_x, max_x);
        end
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        while (!(x == 10'd300 && y == 10'd100) && budget < 110 * 800 * CLK_DIV && !abort) begin
            step();
            budget++;
        end
        checks++;
        if (x !== 10'd300 || y !== 10'd100) begin
            failures++;
            $display("[TB] FAIL mid_reset_reach x=%0d y=%0d required 300,100", x, y);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (x !== 10'd0 || y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_async x=%0d y=%0d hsync=%b vsync=%b required 0,0,1,1",
                     x, y, hsync, vsync);
        end
        checks++;
        if (p_tick !== 1'b0 || video_on !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_decode p_tick=%b video_on=%b required 0,1", p_tick, video_on);
        end
        repeat (2) @(negedge clk);
        release_reset();
        test_first_tick("mid_reset");
    endtask

    task automatic test_frame();
        longint budget = 0;
        bit wrapped = 1'b0;
        longint vs_pix = 0;
        longint vid_pix = 0;
        int min_y = 1023;
        int max_y = -1;
        logic [9:0] px, py;
        px = x;
        py = y;
        while (!wrapped && budget < FRAME_CLKS + 4000 && !abort) begin
            step();
            budget++;
            if (px == 10'd799 && py == 10'd524 && (x != px || y != py)) begin
                wrapped = 1'b1;
                checks++;
                if (x !== 10'd0 || y !== 10'd0) begin
                    failures++;
                    $display("[TB] FAIL frame_wrap x=%0d y=%0d required 0,0", x, y);
                end
            end
            px = x;
            py = y;
        end
        checks++;
        if (!wrapped) begin
            failures++;
            $display("[TB] FAIL frame_wrap_timeout clks=%0d required wrap", budget);
        end
        for (longint i = 0; i < FRAME_CLKS && wrapped && !abort; i++) begin
            if (i > 0) step();
            if (p_tick === 1'b1 && vsync === 1'b0) begin
                vs_pix++;
                if (int'(y) < min_y) min_y = int'(y);
                if (int'(y) > max_y) max_y = int'(y);
            end
            if (p_tick === 1'b1 && video_on === 1'b1) vid_pix++;
        end
        step();
        checks++;
        if (x !== 10'd0 || y !== 10'd0) begin
            failures++;
            $display("[TB] FAIL frame_wrap_second x=%0d y=%0d required 0,0", x, y);
        end
        checks++;
        if (vs_pix != 1600) begin
            failures++;
            $display("[TB] FAIL vsync_low_pixels got=%0d required=1600", vs_pix);
        end
        checks++;
        if (min_y != 490 || max_y != 491) begin
            failures++;
            $display("[TB] FAIL vsync_window y=%0d..%0d required 490..491", min_y, max_y);
        end
        checks++;
        if (vid_pix != 307200) begin
            failures++;
            $display("[TB] FAIL video_on_pixels got=%0d required=307200", vid_pix);
        end
    endtask

    task automatic test_frame_tick();
        longint budget = 0;
        while (tick_n.size() < 3 && budget < 2 * FRAME_CLKS && !abort) begin
            step();
            budget++;
        end
        repeat (2 * CLK_DIV) step();
        checks++;
        if (tick_n.size() != 3) begin
            failures++;
            $display("[TB] FAIL frame_tick_count got=%0d required=3", tick_n.size());
        end
        checks++;
        if (wide_ticks != 0) begin
            failures++;
            $display("[TB] FAIL frame_tick_width extra_clks=%0d required=0", wide_ticks);
        end
        for (int i = 0; i < tick_n.size(); i++) begin
            checks++;
            if (tick_xy[i] !== {10'd0, 10'd481}) begin
                failures++;
                $display("[TB] FAIL frame_tick_pos[%0d] x=%0d y=%0d required 0,481",
                         i, tick_xy[i][19:10], tick_xy[i][9:0]);
            end
            if (i > 0) begin
                checks++;
                if (tick_n[i] - tick_n[i-1] != FRAME_CLKS) begin
                    failures++;
                    $display("[TB] FAIL frame_tick_spacing[%0d] got=%0d required=%0d",
                             i, tick_n[i] - tick_n[i-1], FRAME_CLKS);
                end
            end
        end
        checks++;
        if (frame_count !== EXP_FC_AFTER_3) begin
            failures++;
            $display("[TB] FAIL frame_count_after_3 got=%0d required=%0d", frame_count, EXP_FC_AFTER_3);
        end
    endtask

    initial begin
        $display("[TB] vga_timing_gen bench start");
        test_reset();
        test_line();
        test_mid_reset();
        test_frame();
        test_frame_tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
